// File: rtl/mult_div_unit_pkg.sv
// Shared MDU definitions: operation codes and default latencies, also used by the
// hazard unit and the decoder.
package mult_div_unit_pkg;

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MFHI  = 4'd7,
    OP_MFLO  = 4'd8
  } mdu_op_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;
  localparam int CNT_W_DEF       = 4;

  // True for the operations that occupy the unit for several cycles.
  function automatic logic is_long_op(input logic [3:0] op);
    return (op >= 4'd1) && (op <= 4'd4);
  endfunction

endpackage

// File: rtl/mult_div_unit_counter.sv
// Latency down-counter for the MDU: loads on start, decrements to zero, and flags
// the cycle whose closing edge completes the operation.
module mdu_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             last_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] one_s;

  assign one_s  = {{(CNT_W-1){1'b0}}, 1'b1};
  assign last_o = (cnt_q == one_s);

  // Next count: load, decrement while running, hold at zero when idle.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != {CNT_W{1'b0}}) begin
      cnt_d = cnt_q - one_s;
    end else begin
      cnt_d = {CNT_W{1'b0}};
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers; results are computed from
// the latched operands and committed when the latency counter expires.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic [3:0]       MDUOp,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             Busy,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic [WIDTH-1:0] MDUOut
);

  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
  mdu_op_e            op_q, op_d;
  logic               busy_q, busy_d;
  logic               start_ok_s, last_s;
  logic [CNT_W-1:0]   load_val_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   quot_s, rem_s;

  assign start_ok_s = Start && !busy_q && is_long_op(MDUOp);
  assign load_val_s = ((MDUOp == OP_MULT) || (MDUOp == OP_MULTU)) ?
                      CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);

  mdu_counter #(.CNT_W(CNT_W)) u_counter (
    .clk        (clk),
    .reset      (reset),
    .load_i     (start_ok_s),
    .load_val_i (load_val_s),
    .last_o     (last_s)
  );

  // Product from the latched operands; sign-extending gives the signed product.
  always_comb begin
    prod_s = {(2*WIDTH){1'b0}};
    if (op_q == OP_MULT) begin
      prod_s = {{WIDTH{a_q[WIDTH-1]}}, a_q} * {{WIDTH{b_q[WIDTH-1]}}, b_q};
    end else begin
      prod_s = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
    end
  end

  // Quotient/remainder; MIN / -1 is pinned explicitly so it wraps without relying on tool behaviour.
  always_comb begin
    quot_s = {WIDTH{1'b0}};
    rem_s  = {WIDTH{1'b0}};
    if (op_q == OP_DIV) begin
      if ((a_q == {1'b1, {(WIDTH-1){1'b0}}}) && (b_q == {WIDTH{1'b1}})) begin
        quot_s = a_q;
        rem_s  = {WIDTH{1'b0}};
      end else begin
        quot_s = $signed(a_q) / $signed(b_q);
        rem_s  = $signed(a_q) % $signed(b_q);
      end
    end else begin
      quot_s = a_q / b_q;
      rem_s  = a_q % b_q;
    end
  end

  // Next-state for operand latches, busy flag and HI/LO.
  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    op_d   = op_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    busy_d = busy_q;
    if (start_ok_s) begin
      a_d    = SrcA;
      b_d    = SrcB;
      op_d   = mdu_op_e'(MDUOp);
      busy_d = 1'b1;
    end else if (busy_q) begin
      if (last_s) begin
        busy_d = 1'b0;
        case (op_q)
          OP_MULT, OP_MULTU: begin
            hi_d = prod_s[2*WIDTH-1:WIDTH];
            lo_d = prod_s[WIDTH-1:0];
          end
          OP_DIV, OP_DIVU: begin
            // A zero divisor still costs the full latency but leaves HI/LO alone.
            if (b_q != {WIDTH{1'b0}}) begin
              hi_d = rem_s;
              lo_d = quot_s;
            end else begin
              hi_d = hi_q;
              lo_d = lo_q;
            end
          end
          default: begin
            hi_d = hi_q;
            lo_d = lo_q;
          end
        endcase
      end else begin
        busy_d = 1'b1;
      end
    end else begin
      case (MDUOp)
        OP_MTHI: hi_d = SrcA;
        OP_MTLO: lo_d = SrcA;
        default: begin
          hi_d = hi_q;
          lo_d = lo_q;
        end
      endcase
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q    <= {WIDTH{1'b0}};
      b_q    <= {WIDTH{1'b0}};
      op_q   <= OP_NONE;
      hi_q   <= {WIDTH{1'b0}};
      lo_q   <= {WIDTH{1'b0}};
      busy_q <= 1'b0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      op_q   <= op_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      busy_q <= busy_d;
    end
  end

  assign Busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

  // MFHI/MFLO read path.
  always_comb begin
    case (MDUOp)
      OP_MFHI: MDUOut = hi_q;
      OP_MFLO: MDUOut = lo_q;
      default: MDUOut = {WIDTH{1'b0}};
    endcase
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed, table-driven bench for mult_div_unit plus hand-written multi-cycle sequences.
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  logic        clk;
  logic        reset;
  logic        Start;
  logic [3:0]  MDUOp;
  logic [31:0] SrcA, SrcB;
  logic        Busy;
  logic [31:0] HI, LO, MDUOut;

  int tests = 0;
  int fails = 0;

  mult_div_unit dut (
    .clk    (clk),
    .reset  (reset),
    .Start  (Start),
    .MDUOp  (MDUOp),
    .SrcA   (SrcA),
    .SrcB   (SrcB),
    .Busy   (Busy),
    .HI     (HI),
    .LO     (LO),
    .MDUOut (MDUOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          lat;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Start a long op at the next edge and return the number of edges until Busy drops.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat);
    @(negedge clk);
    Start = 1'b1; MDUOp = op; SrcA = a; SrcB = b;
    @(posedge clk); #1;
    Start = 1'b0; MDUOp = OP_NONE;
    lat = 0;
    while (Busy && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    int lat;
    vecs[0] = '{OP_MULT,  32'hFFFF_FFFE, 32'h0000_0003, 5,  32'hFFFF_FFFF, 32'hFFFF_FFFA};
    vecs[1] = '{OP_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 5,  32'h0000_0001, 32'hFFFF_FFFE};
    vecs[2] = '{OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3] = '{OP_DIVU,  32'h0000_0007, 32'h0000_0000, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[4] = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0000, 32'h8000_0000};
    vecs[5] = '{OP_DIVU,  32'h0000_0064, 32'h0000_0007, 10, 32'h0000_0002, 32'h0000_000E};
    vecs[6] = '{OP_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 10, 32'h0000_0001, 32'hFFFF_FFFD};
    vecs[7] = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 5,  32'h4000_0000, 32'h0000_0000};
    vecs[8] = '{OP_MULTU, 32'h0001_0000, 32'h0001_0000, 5,  32'h0000_0001, 32'h0000_0000};
    vecs[9] = '{OP_MULT,  32'h0000_0007, 32'hFFFF_FFFF, 5,  32'hFFFF_FFFF, 32'hFFFF_FFF9};

    reset = 1'b1; Start = 1'b0; MDUOp = OP_NONE; SrcA = 32'h0; SrcB = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("reset_busy", {31'h0, Busy}, 32'h0);
    check("reset_hi", HI, 32'h0);
    check("reset_lo", LO, 32'h0);
    check("reset_mduout", MDUOut, 32'h0);

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat);
      check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("v%0d_hi", i), HI, vecs[i].hi);
      check($sformatf("v%0d_lo", i), LO, vecs[i].lo);
      @(negedge clk);
      MDUOp = OP_MFHI; #1;
      check($sformatf("v%0d_mfhi", i), MDUOut, vecs[i].hi);
      MDUOp = OP_MFLO; #1;
      check($sformatf("v%0d_mflo", i), MDUOut, vecs[i].lo);
      MDUOp = OP_NONE;
    end

    // MTHI / MTLO in idle, then MTLO while busy is ignored.
    @(negedge clk);
    MDUOp = OP_MTHI; SrcA = 32'h0000_1234;
    @(negedge clk);
    MDUOp = OP_MTLO; SrcA = 32'h0000_5678;
    @(negedge clk);
    MDUOp = OP_MFHI; #1;
    check("mthi_mfhi", MDUOut, 32'h0000_1234);
    MDUOp = OP_MFLO; #1;
    check("mtlo_mflo", MDUOut, 32'h0000_5678);
    Start = 1'b1; MDUOp = OP_MULT; SrcA = 32'h2; SrcB = 32'h3;
    @(negedge clk);
    Start = 1'b0; MDUOp = OP_MTLO; SrcA = 32'hDEAD_BEEF;
    @(negedge clk);
    check("mtlo_busy_lo", LO, 32'h0000_5678);
    MDUOp = OP_MFLO; #1;
    check("mflo_busy_preop", MDUOut, 32'h0000_5678);
    MDUOp = OP_NONE;
    repeat (5) @(negedge clk);
    check("mult_after_mt_busy", {31'h0, Busy}, 32'h0);
    check("mult_after_mt_lo", LO, 32'h0000_0006);

    // Operands change and Start re-pulses mid-run: first operands win, Busy still 5.
    @(negedge clk);
    Start = 1'b1; MDUOp = OP_MULT; SrcA = 32'h3; SrcB = 32'h4;
    @(posedge clk); #1;
    Start = 1'b0; SrcA = 32'h5; SrcB = 32'h5;
    @(posedge clk); #1;
    Start = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0; MDUOp = OP_NONE;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("restart_busy_c4", {31'h0, Busy}, 32'h1);
    @(posedge clk); #1;
    check("restart_busy_c5", {31'h0, Busy}, 32'h0);
    check("restart_hi", HI, 32'h0);
    check("restart_lo", LO, 32'h0000_000C);

    // Asynchronous reset in the middle of a divide.
    @(negedge clk);
    Start = 1'b1; MDUOp = OP_DIV; SrcA = 32'd100; SrcB = 32'd3;
    @(posedge clk); #1;
    Start = 1'b0; MDUOp = OP_NONE;
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_busy", {31'h0, Busy}, 32'h0);
    check("async_rst_hi", HI, 32'h0);
    check("async_rst_lo", LO, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    check("post_rst_busy", {31'h0, Busy}, 32'h0);
    check("post_rst_hi", HI, 32'h0);
    check("post_rst_lo", LO, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
